// File: rtl/axis_gz_stream_arbiter.sv
// -----------------------------------------------------------------------------
// axis_gz_stream_arbiter
//
// Packet-atomic round-robin arbiter that merges N_SRC 32-bit AXI-stream
// sources (gzip compressor outputs) onto one AXI-stream master. Once a
// source wins, its whole packet (through the tlast beat) passes before any
// other source is considered. The beat owner index is carried on m_tid.
//
// Parameters:
//   N_SRC : number of sources (2..16)
//   ID_W  : width of m_tid, 2**ID_W must be >= N_SRC
//
// Ports:
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   s_tvalid  in   [N_SRC]     per-source valid
//   s_tready  out  [N_SRC]     per-source ready (combinational from state and m_tready)
//   s_tdata   in   [32*N_SRC]  source i data in [32*i+31:32*i]
//   s_tlast   in   [N_SRC]     per-source end of packet
//   s_tkeep   in   [4*N_SRC]   source i byte enables in [4*i+3:4*i]
//   m_tready  in   downstream ready
//   m_tvalid  out  output valid (registered)
//   m_tdata   out  [32] output data (registered)
//   m_tlast   out  output end of packet (registered)
//   m_tkeep   out  [4] output byte enables (registered)
//   m_tid     out  [ID_W] owning source index (registered)
// -----------------------------------------------------------------------------
module axis_gz_stream_arbiter #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_SRC-1:0]    s_tvalid,
    output logic [N_SRC-1:0]    s_tready,
    input  logic [32*N_SRC-1:0] s_tdata,
    input  logic [N_SRC-1:0]    s_tlast,
    input  logic [4*N_SRC-1:0]  s_tkeep,
    input  logic                m_tready,
    output logic                m_tvalid,
    output logic [31:0]         m_tdata,
    output logic                m_tlast,
    output logic [3:0]          m_tkeep,
    output logic [ID_W-1:0]     m_tid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [ID_W-1:0] grant_r;
    logic [ID_W-1:0] rr_ptr_r;

    logic            m_tvalid_r;
    logic [31:0]     m_tdata_r;
    logic            m_tlast_r;
    logic [3:0]      m_tkeep_r;
    logic [ID_W-1:0] m_tid_r;

    logic [31:0]     src_data_s [N_SRC];
    logic [3:0]      src_keep_s [N_SRC];
    logic            sel_found_s;
    logic [ID_W-1:0] sel_idx_s;
    logic [ID_W-1:0] cand_s;
    logic            free_s;
    logic            accept_s;
    logic            grant_last_s;
    logic [N_SRC-1:0] s_tready_s;

    // (base + off) mod N_SRC; both operands are below N_SRC so one subtraction suffices
    function automatic logic [ID_W-1:0] idx_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_SRC) begin
            sum = sum - N_SRC;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    // Output slot can take a new beat when empty or being drained this cycle
    assign free_s       = ~m_tvalid_r | m_tready;
    assign grant_last_s = s_tlast[grant_r];
    assign accept_s     = (state_r == ST_BUSY) & s_tvalid[grant_r] & free_s;

    // Split the flat source buses into per-source slices
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_data_s[i] = s_tdata[32*i +: 32];
            src_keep_s[i] = s_tkeep[4*i +: 4];
        end
    end

    // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... (mod N_SRC)
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand_s = idx_add(rr_ptr_r, k);
            if (!sel_found_s && s_tvalid[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE picks a winner, BUSY holds until the tlast beat is taken
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && grant_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: only the granted source sees ready, and only while the slot is free
    always_comb begin
        s_tready_s = '0;
        case (state_r)
            ST_BUSY: s_tready_s[grant_r] = free_s;
            ST_IDLE: s_tready_s = '0;
            default: s_tready_s = '0;
        endcase
    end

    assign s_tready = s_tready_s;

    // Grant capture in IDLE; pointer advances past the owner when its packet ends
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            if (state_r == ST_IDLE && sel_found_s) begin
                grant_r <= sel_idx_s;
            end else begin
                grant_r <= grant_r;
            end
            if (accept_s && grant_last_s) begin
                rr_ptr_r <= idx_add(grant_r, 32'sd1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Output register slot: load on accept, empty when drained, otherwise hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 32'h0000_0000;
            m_tlast_r  <= 1'b0;
            m_tkeep_r  <= 4'h0;
            m_tid_r    <= '0;
        end else begin
            if (accept_s) begin
                m_tvalid_r <= 1'b1;
                m_tdata_r  <= src_data_s[grant_r];
                m_tlast_r  <= grant_last_s;
                m_tkeep_r  <= src_keep_s[grant_r];
                m_tid_r    <= grant_r;
            end else if (free_s) begin
                m_tvalid_r <= 1'b0;
            end else begin
                m_tvalid_r <= m_tvalid_r;
            end
        end
    end

    assign m_tvalid = m_tvalid_r;
    assign m_tdata  = m_tdata_r;
    assign m_tlast  = m_tlast_r;
    assign m_tkeep  = m_tkeep_r;
    assign m_tid    = m_tid_r;

endmodule

// File: tb/tb_axis_gz_stream_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for axis_gz_stream_arbiter: per-source beat queues drive the inputs,
// a transaction-level owner/slot model predicts every output each cycle, a
// per-source scoreboard tracks beat order, and directed tests pin literals.
// -----------------------------------------------------------------------------
module tb_axis_gz_stream_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  gap;
    } beat_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
        logic [3:0]     keep;
        logic           last;
    } obeat_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tready;
    logic [32*N-1:0]   s_tdata = '0;
    logic [N-1:0]      s_tlast = '0;
    logic [4*N-1:0]    s_tkeep = '0;
    logic              m_tready = 1'b1;
    logic              m_tvalid;
    logic [31:0]       m_tdata;
    logic              m_tlast;
    logic [3:0]        m_tkeep;
    logic [IDW-1:0]    m_tid;

    axis_gz_stream_arbiter #(.N_SRC(N), .ID_W(IDW)) dut (
        .clk(clk), .rstn(rstn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tkeep(s_tkeep),
        .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tkeep(m_tkeep), .m_tid(m_tid)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    beat_t          src_q [N][$];
    beat_t          exp_q [N][$];
    obeat_t         out_log [$];
    logic [IDW-1:0] order_q [$];
    int             gap_cnt [N];
    bit             gap_loaded [N];
    logic [N-1:0]   hs_r = '0;

    int t_req2 = -1, t_rdy2 = -1, t_mv = -1, t_rdy1 = -1, last0_cyc = -1, src3_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model: owner index + one output slot ------
    int             mdl_owner = -1;
    int             mdl_rr    = 0;
    logic           mdl_valid = 1'b0;
    logic [31:0]    mdl_data  = '0;
    logic           mdl_last  = 1'b0;
    logic [3:0]     mdl_keep  = '0;
    logic [IDW-1:0] mdl_id    = '0;
    logic           mdl_free;
    assign mdl_free = !mdl_valid || m_tready;

    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdl_owner <= -1; mdl_rr <= 0; mdl_valid <= 1'b0;
            mdl_data <= '0; mdl_last <= 1'b0; mdl_keep <= '0; mdl_id <= '0;
        end else begin
            if (mdl_free) mdl_valid <= 1'b0;
            if (mdl_owner < 0) begin
                mdl_owner <= rr_pick(s_tvalid, mdl_rr);
            end else if (s_tvalid[mdl_owner] && mdl_free) begin
                mdl_valid <= 1'b1;
                mdl_data  <= s_tdata[32*mdl_owner +: 32];
                mdl_keep  <= s_tkeep[4*mdl_owner +: 4];
                mdl_last  <= s_tlast[mdl_owner];
                mdl_id    <= IDW'(mdl_owner);
                if (s_tlast[mdl_owner]) begin
                    mdl_owner <= -1;
                    mdl_rr    <= (mdl_owner + 1) % N;
                end
            end
        end
    end

    // ---------------- compare process (negedge) -----------------------------
    initial begin : compare_proc
        logic [63:0] cur_v, exp_v;
        logic [39:0] out_v, prev_out;
        logic        prev_hold;
        logic [N-1:0] exp_rdy;
        beat_t       b;
        obeat_t      o;
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            exp_rdy = '0;
            if (mdl_owner >= 0 && mdl_free) exp_rdy = N'(1) << mdl_owner;
            cur_v = {20'd0, s_tready, m_tvalid, m_tdata, m_tlast, m_tkeep, m_tid};
            exp_v = {20'd0, exp_rdy, mdl_valid, mdl_data, mdl_last, mdl_keep, mdl_id};
            chk("cycle_model", cur_v, exp_v);
            out_v = {m_tvalid, m_tdata, m_tlast, m_tkeep, m_tid};
            if (prev_hold && rstn) chk("stall_stable", {24'd0, out_v}, {24'd0, prev_out});
            prev_hold = rstn && m_tvalid && !m_tready;
            prev_out  = out_v;

            hs_r = s_tvalid & s_tready;
            for (int i = 0; i < N; i++) begin
                if (hs_r[i]) begin
                    b.data = s_tdata[32*i +: 32];
                    b.keep = s_tkeep[4*i +: 4];
                    b.last = s_tlast[i];
                    b.gap  = 8'd0;
                    exp_q[i].push_back(b);
                    if (i == 3) src3_cnt++;
                    if (i == 0 && s_tlast[0]) last0_cyc = cyc;
                end
            end
            if (t_req2 < 0 && s_tvalid[2]) t_req2 = cyc;
            if (t_rdy2 < 0 && s_tready[2]) t_rdy2 = cyc;
            if (t_mv < 0 && m_tvalid) t_mv = cyc;
            if (t_rdy1 < 0 && s_tready[1]) t_rdy1 = cyc;

            if (rstn && m_tvalid && m_tready) begin
                total_cnt++;
                if (exp_q[m_tid].size() == 0) begin
                    $display("FAIL sb_extra_beat: got beat %0h from source %0d, expected none", m_tdata, m_tid);
                end else begin
                    pass_cnt++;
                    b = exp_q[m_tid].pop_front();
                    chk("sb_order", {27'd0, m_tdata, m_tkeep, m_tlast}, {27'd0, b.data, b.keep, b.last});
                end
                o = {m_tid, m_tdata, m_tkeep, m_tlast};
                out_log.push_back(o);
                if (m_tlast) order_q.push_back(m_tid);
            end
        end
    end

    // ---------------- source drivers (posedge + 1) --------------------------
    initial begin : drive_proc
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_r[i]) begin
                    if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                    gap_loaded[i] = 1'b0;
                end
                if (src_q[i].size() > 0) begin
                    if (!gap_loaded[i]) begin
                        gap_cnt[i]    = int'(src_q[i][0].gap);
                        gap_loaded[i] = 1'b1;
                    end
                    if (gap_cnt[i] > 0) begin
                        s_tvalid[i] = 1'b0;
                        gap_cnt[i]--;
                    end else begin
                        s_tvalid[i]          = 1'b1;
                        s_tdata[32*i +: 32]  = src_q[i][0].data;
                        s_tkeep[4*i +: 4]    = src_q[i][0].keep;
                        s_tlast[i]           = src_q[i][0].last;
                    end
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int src, input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
        beat_t b;
        b = {d, k, l, 8'(gap)};
        src_q[src].push_back(b);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return !m_tvalid;
    endfunction

    function automatic logic [63:0] order_code();
        logic [63:0] c;
        c = '0;
        foreach (order_q[k]) c = (c << 4) | 64'(order_q[k]);
        return c;
    endfunction

    task automatic wait_drain(input string name, input int max);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            step(1);
            n++;
            done = all_empty();
        end
        total_cnt++;
        if (done) pass_cnt++;
        else $display("FAIL %s: still busy after %0d cycles, expected drained", name, max);
        step(1);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            gap_loaded[i] = 1'b0;
            gap_cnt[i]    = 0;
        end
        hs_r = '0;
        out_log.delete();
        order_q.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_all();
        step(2);
        rstn = 1'b1;
        step(1);
    endtask

    // ---------------- directed tests ----------------------------------------
    initial begin : tests
        obeat_t exp2 [3];
        obeat_t exp4 [4];
        int     n;
        for (int i = 0; i < N; i++) begin
            gap_cnt[i] = 0;
            gap_loaded[i] = 1'b0;
        end
        step(3);
        rstn = 1'b1;

        // Reset state with no requests
        step(5);
        chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_s_tready", {60'd0, s_tready}, 64'd0);
        chk("rst_m_tid", {62'd0, m_tid}, 64'd0);

        // Single source 2, 3-beat packet with partial tkeep on tlast
        t_req2 = -1; t_rdy2 = -1; t_mv = -1;
        out_log.delete();
        push(2, 32'h11223344, 4'hF, 1'b0, 0);
        push(2, 32'h55667788, 4'hF, 1'b0, 0);
        push(2, 32'h000000AA, 4'h1, 1'b1, 0);
        wait_drain("single_src2", 50);
        chk("grant_latency", 64'(t_rdy2 - t_req2), 64'd1);
        chk("out_latency", 64'(t_mv - t_rdy2), 64'd1);
        chk("src2_beats", 64'(out_log.size()), 64'd3);
        exp2[0] = {2'd2, 32'h11223344, 4'hF, 1'b0};
        exp2[1] = {2'd2, 32'h55667788, 4'hF, 1'b0};
        exp2[2] = {2'd2, 32'h000000AA, 4'h1, 1'b1};
        for (int k = 0; k < 3 && k < out_log.size(); k++) chk("src2_beat", 64'(out_log[k]), 64'(exp2[k]));

        // All four sources at once from rr_ptr=0
        do_reset();
        for (int s = 0; s < N; s++) begin
            push(s, 32'hA0000000 | (32'(s) << 8), 4'hF, 1'b0, 0);
            push(s, 32'hA0000001 | (32'(s) << 8), 4'h3, 1'b1, 0);
        end
        wait_drain("all_four", 100);
        chk("order4_len", 64'(order_q.size()), 64'd4);
        chk("order4", order_code(), 64'h0123);

        // Move rr_ptr to 1, then sources 0 and 3 compete
        push(0, 32'hA0000F00, 4'hF, 1'b1, 0);
        wait_drain("rr_setup", 30);
        order_q.delete();
        push(0, 32'hD0000000, 4'hF, 1'b0, 0);
        push(0, 32'hD0000001, 4'h0, 1'b1, 0);
        push(3, 32'hD3000000, 4'hF, 1'b0, 0);
        push(3, 32'hD3000001, 4'hF, 1'b1, 0);
        wait_drain("pair_0_3", 60);
        chk("order30_len", 64'(order_q.size()), 64'd2);
        chk("order30", order_code(), 64'h30);

        // Backpressure on a source-1 packet
        out_log.delete();
        for (int k = 0; k < 4; k++) begin
            exp4[k] = {2'd1, 32'hB1000000 + 32'(k), 4'hF, (k == 3)};
            push(1, 32'hB1000000 + 32'(k), 4'hF, (k == 3), 0);
        end
        n = 0;
        while (!m_tvalid && n < 20) begin
            step(1);
            n++;
        end
        chk("bp_start", {63'd0, m_tvalid}, 64'd1);
        m_tready = 1'b1; step(1);
        m_tready = 1'b0; step(1);
        m_tready = 1'b0; step(1);
        m_tready = 1'b1; step(1);
        wait_drain("backpressure", 40);
        chk("bp_beats", 64'(out_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < out_log.size(); k++) chk("bp_beat", 64'(out_log[k]), 64'(exp4[k]));

        // Interleave guard: source 0 gaps mid-packet, source 1 keeps requesting
        order_q.delete();
        t_rdy1 = -1; last0_cyc = -1;
        push(0, 32'hE0000000, 4'hF, 1'b0, 0);
        push(0, 32'hE0000001, 4'hF, 1'b0, 0);
        push(0, 32'hE0000002, 4'hF, 1'b0, 4);
        push(0, 32'hE0000003, 4'h7, 1'b1, 0);
        push(1, 32'hE1000000, 4'hF, 1'b0, 0);
        push(1, 32'hE1000001, 4'hF, 1'b1, 0);
        wait_drain("interleave", 80);
        chk("guard_order", order_code(), 64'h01);
        chk("guard_ready1", 64'(t_rdy1), 64'(last0_cyc + 2));

        // Reset in the middle of a source-3 packet
        src3_cnt = 0;
        for (int k = 0; k < 5; k++) push(3, 32'hC3000000 + 32'(k), 4'hF, (k == 4), 0);
        n = 0;
        while (src3_cnt < 2 && n < 30) begin
            step(1);
            n++;
        end
        chk("mid_pkt_beats", 64'(src3_cnt), 64'd2);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("async_rst_tready", {60'd0, s_tready}, 64'd0);
        clear_all();
        step(2);
        rstn = 1'b1;
        step(3);
        chk("no_tail_beats", 64'(out_log.size()), 64'd0);
        push(0, 32'hF0000000, 4'hF, 1'b1, 0);
        push(3, 32'hF3000000, 4'hF, 1'b1, 0);
        wait_drain("post_reset", 40);
        chk("post_reset_order", order_code(), 64'h03);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
